// File: rtl/boa_uart_pkg.sv
// Shared constants and types for the oversampling UART receiver.
// Frame format is fixed 8N1 with four ticks per bit.
package boa_uart_pkg;

    localparam int OVERSAMPLE = 4;
    localparam int DATA_BITS  = 8;
    localparam int CNT_W      = $clog2(OVERSAMPLE);
    localparam int BIT_W      = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// The reset value matches the line's idle level.
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_os4.sv
// 8N1 UART receiver, 4x oversampled from a tick enable.
// One-byte holding register with valid/ready and overrun.
module uart_rx_os4
    import boa_uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 rxd_s;
    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bitcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 stop_tick;
    logic                 done;
    logic                 bad_stop;

    uart_rx_sync #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rxd),
        .q  (rxd_s)
    );

    assign stop_tick = tick && (state == RX_STOP) && (cnt == CNT_LAST);
    assign done      = stop_tick && rxd_s;
    assign bad_stop  = stop_tick && !rxd_s;
    assign busy      = (state != RX_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RX_IDLE;
            cnt    <= '0;
            bitcnt <= '0;
            shreg  <= '0;
        end else if (tick) begin
            unique case (state)
                RX_IDLE: begin
                    if (!rxd_s) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    cnt <= cnt + 1'b1;
                    // Mid-bit check rejects glitches shorter than half a bit
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            state <= RX_IDLE;
                        end else begin
                            state  <= RX_DATA;
                            bitcnt <= '0;
                        end
                    end
                end
                RX_DATA: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        shreg[bitcnt] <= rxd_s;
                        if (bitcnt == BIT_LAST) begin
                            state <= RX_STOP;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= rxd_s ? RX_IDLE : RX_BREAK;
                    end
                end
                RX_BREAK: begin
                    if (rxd_s) begin
                        state <= RX_IDLE;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

    // Holding register; a completing byte wins over a same-cycle read
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            overrun   <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_os4.md
UART_RX_OS4 -- requirements
Module: uart_rx_os4

Interface
REQ-001 SHALL have no parameters; oversample ratio and frame format come from package constants.
REQ-002 clk  input  1  system clock; sole clock, all logic on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 tick  input  1  one-clk pulse at 4x baud rate, from the team's clock divider used as an enable, never as a clock.
REQ-005 rxd  input  1  asynchronous serial line, idle high.
REQ-006 rx_data  output  8  received byte, stable while rx_valid is high.
REQ-007 rx_valid  output  1  rx_data holds an unread byte.
REQ-008 rx_ready  input  1  consumer accepts byte when rx_valid && rx_ready on a clk edge.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-011 overrun  output  1  one-clk pulse: completed byte dropped because holding register full.

Function
REQ-012 rxd SHALL pass a 2-flop synchronizer (reset value 1) before use; rxd_s denotes its output.
REQ-013 Frame SHALL be 8N1: start bit 0, 8 data bits LSB-first, one stop bit 1.
REQ-014 States SHALL be IDLE, START, DATA, STOP, BREAK; tick counter cnt 2 bits, bit counter 3 bits.
REQ-015 State and counters SHALL change only on clk edges with tick=1, except handshake/pulse logic, which runs every clk.
REQ-016 IDLE: on tick with rxd_s=0 -> START, cnt=0.
REQ-017 START: cnt increments per tick; on the tick where cnt reaches 2 (mid-bit) sample rxd_s: 0 -> DATA, cnt=0, bitcnt=0; 1 -> IDLE (glitch rejected, no output activity).
REQ-018 DATA: on every 4th tick after previous sample (cnt wraps 3->0) shift rxd_s into bit bitcnt; after bit 7 -> STOP, cnt=0.
REQ-019 STOP: on 4th tick sample rxd_s: 1 -> byte complete, IDLE; 0 -> frame_err pulse, byte discarded, BREAK.
REQ-020 BREAK: remain until tick with rxd_s=1, then IDLE; no start detection while in BREAK.
REQ-021 Byte complete with rx_valid=0: rx_data<=byte, rx_valid<=1 on that edge.
REQ-022 Byte complete with rx_valid=1 and rx_ready=1 same cycle: new byte loaded, rx_valid stays 1, no overrun.
REQ-023 Byte complete with rx_valid=1 and rx_ready=0: new byte dropped, rx_data unchanged, overrun pulse.
REQ-024 rx_valid && rx_ready without completion: rx_valid<=0 next edge; rx_data holds value.
REQ-025 Latency: rx_valid SHALL rise on the clk edge of the stop-bit sampling tick.
REQ-026 frame_err and overrun SHALL never be high more than one clk per event.

Reset
REQ-027 On rst: state IDLE, cnt=0, bitcnt=0, shift register 0, rx_data=0, rx_valid=0, busy=0, frame_err=0, overrun=0, synchronizer flops 1.
REQ-028 rst mid-frame SHALL abandon the frame with no output pulse; reception resumes with the next falling edge after rst deasserts.

Structure
REQ-029 Shared package boa_uart_pkg SHALL hold OVERSAMPLE=4, DATA_BITS=8, and the rx state enum type.
REQ-030 Synchronizer SHALL be sub-module uart_rx_sync (2-flop, reset value parameterizable, default 1); all else in uart_rx_os4.

Verification
REQ-031 Send 0xA5 framed 8N1 at 4 ticks/bit, rx_ready=0 -> rx_data=0xA5, rx_valid=1, no pulses; then rx_ready=1 -> rx_valid=0 next edge.
REQ-032 rxd low for 1 tick only, then high -> returns to IDLE, rx_valid stays 0, busy falls within 3 ticks.
REQ-033 Send 0x3C with stop bit 0, rxd held low 20 ticks then high -> one frame_err pulse, rx_valid=0, busy high until first tick with rxd_s=1.
REQ-034 Send 0x11 then 0x22 back-to-back, rx_ready=0 -> rx_data=0x11, one overrun pulse at second stop sample.
REQ-035 Send 0x11 then 0x22 with rx_ready=1 pulsed exactly on second completion edge -> rx_data=0x22, rx_valid=1, no overrun.
REQ-036 Assert rst during bit 4 of 0xFF, then send 0x5A -> all outputs at reset values, then rx_data=0x5A.
